hcsr04_scheduler: RTL and testbench
===================================

Name: hcsr04_scheduler

Overview:
Time-multiplexes one HC-SR04 ranging core across N_CH ultrasonic sensors.
- Selects a channel round-robin, fires the core's start, and waits for a valid result or a timeout.
- Stores a per-channel distance (mm) and enforces a fixed measurement slot so sensor echoes die out.
- Sits between the crossbar/CPU side and the ranging core plus its trig/echo mux.

Parameters:
N_CH, 4, number of sensor channels (2..8)
PERIOD_CYC, 3_000_000, slot length in clk cycles (60 ms at 50 MHz), measured from ISSUE
TIMEOUT_CYC, 2_000_000, cycles after ISSUE before declaring no result (40 ms); requires TIMEOUT_CYC+3 < PERIOD_CYC
DIST_W, 12, distance width (mm)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  reset; asynchronous, active-high
en  in  1  enable continuous scanning
ch_mask  in  N_CH  channels included in the scan
core_start  out  1  one-cycle start pulse to the ranging core
core_val  in  1  ranging core result-valid pulse
core_dist  in  DIST_W  ranging core distance, qualified by core_val
core_rst_n  out  1  active-low reset to the ranging core
sel  out  $clog2(N_CH)  trig/echo mux select; stable from ISSUE to end of slot
res_dist  out  N_CH*DIST_W  last good distance per channel; ch k occupies bits [k*DIST_W +: DIST_W]
res_new  out  N_CH  one-cycle pulse on channel update
res_err  out  N_CH  sticky timeout flag per channel
busy  out  1  high in every state except IDLE

Behaviour:
Reset values:
- Asserting rst, at any time, forces IDLE immediately.
- core_start=0, sel=0, res_dist=0, res_new=0, res_err=0, busy=0.
- core_rst_n=0, so the core is held in reset. It rises on the first clk edge after rst deasserts.
- Internal last_ch=N_CH-1, so the first pick is ch0.
- All outputs are registered.

States: IDLE, ISSUE, WAIT_RES, ABORT, HOLDOFF. One slot timer, width $clog2(PERIOD_CYC).
- IDLE: if en && |ch_mask, set sel and last_ch to the next channel, then go to ISSUE.
  - Next channel = first set mask bit searching last_ch+1, last_ch+2, ... with wrap-around.
  - Otherwise stay in IDLE.
- ISSUE: core_start=1 for exactly this cycle; timer=0; go to WAIT_RES.
- WAIT_RES: timer increments every cycle.
  - If core_val: res_dist[sel]<=core_dist; res_new[sel]=1 for one cycle; res_err[sel]<=0; go to HOLDOFF.
  - Else if timer==TIMEOUT_CYC-1: res_err[sel]<=1; go to ABORT.
  - core_val and the timeout terminal in the same cycle count as success (val wins).
- ABORT: core_rst_n=0 for exactly 2 cycles, recovering a core stuck waiting for echo; then HOLDOFF. The timer keeps counting.
- HOLDOFF: the timer keeps counting. When timer==PERIOD_CYC-1, go to IDLE.
  - Consecutive start pulses are therefore exactly PERIOD_CYC+1 cycles apart: one cycle in IDLE plus the slot.

Ignored or deferred events:
- core_val outside WAIT_RES is ignored.
- ch_mask is sampled only in IDLE. Clearing the current channel's bit mid-slot does not abort the slot; the result is still stored.
- en deasserted mid-slot: the slot completes, including HOLDOFF, then the FSM stays in IDLE.
- en=1 with ch_mask=0: stay in IDLE, busy=0.
- With a single channel in the mask, the same channel is reselected every slot.

Decomposition:
- Package hcsr04_pkg holds:
  - the sched_state_t enum;
  - DIST_W=12;
  - default PERIOD_CYC/TIMEOUT_CYC constants;
  - CORE_ABORT_CYC=2.
- One sub-module, hcsr04_rr_pick: combinational, inputs mask and last_ch, outputs next_ch and any_valid.
- The FSM, timer and result registers stay in the top module.

Test Plan:
All scenarios use PERIOD_CYC=200, TIMEOUT_CYC=100, N_CH=4, and a behavioural core model.
1. Reset: assert rst mid-WAIT_RES -> same cycle: busy=0, core_rst_n=0, res_*=0. First clk after release -> core_rst_n=1.
2. Single channel: mask=4'b0001, en=1; model returns val with dist=12'd1234 40 cycles after start -> res_dist[0]=1234, res_new[0] pulses once, next core_start exactly 201 cycles after the first.
3. Round-robin: mask=4'b1011, model always answers -> sel sequence 0,1,3,0,1; ch2 never selected; each res_new matches sel.
4. Timeout: model silent on ch1 -> 100 cycles after start: res_err[1]=1, core_rst_n low 2 cycles, next start on schedule. A later success on ch1 clears res_err[1] with a new res_dist.
5. Race: core_val asserted on the cycle timer==99 -> success path taken: res_err unchanged at 0, no core_rst_n pulse.
6. Disable: drop en 10 cycles after start -> result still stored, busy falls at cycle 200, no further core_start. mask=0 with en=1 -> no start, busy=0.

Source files
------------

// File: rtl/hcsr04_pkg.sv
// Shared types and constants for the multi-channel HC-SR04 scan scheduler.
// Latency/backpressure: none, declarations only.
package hcsr04_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RES,
        ST_ABORT,
        ST_HOLDOFF
    } sched_state_t;

    localparam int DIST_W          = 12;
    localparam int DEF_PERIOD_CYC  = 3_000_000;
    localparam int DEF_TIMEOUT_CYC = 2_000_000;
    localparam int CORE_ABORT_CYC  = 2;

endpackage

// File: rtl/hcsr04_rr_pick.sv
// Round-robin channel picker: first set mask bit after last_ch, wrapping around.
// Latency: combinational; no backpressure.
module hcsr04_rr_pick #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]         mask,
    input  logic [$clog2(N_CH)-1:0] last_ch,
    output logic [$clog2(N_CH)-1:0] next_ch,
    output logic                    any_valid
);
    localparam int CW = $clog2(N_CH);

    // Wrapped candidates first, then channels above last_ch override them, so the
    // lowest channel strictly above last_ch wins whenever one exists.
    always_comb begin
        next_ch   = '0;
        any_valid = 1'b0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (mask[j] && (j <= int'(last_ch))) begin
                next_ch   = CW'(j);
                any_valid = 1'b1;
            end
        end
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (mask[j] && (j > int'(last_ch))) begin
                next_ch   = CW'(j);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hcsr04_scheduler.sv
// Time-multiplexes one HC-SR04 ranging core over N_CH sensors in fixed PERIOD_CYC slots.
// Latency: start pulse one cycle after IDLE pick, result one cycle after core_val; no backpressure.
module hcsr04_scheduler
    import hcsr04_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int PERIOD_CYC  = DEF_PERIOD_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_CH-1:0]          ch_mask,
    output logic                     core_start,
    input  logic                     core_val,
    input  logic [DIST_W-1:0]        core_dist,
    output logic                     core_rst_n,
    output logic [$clog2(N_CH)-1:0]  sel,
    output logic [N_CH*DIST_W-1:0]   res_dist,
    output logic [N_CH-1:0]          res_new,
    output logic [N_CH-1:0]          res_err,
    output logic                     busy
);
    localparam int CW = $clog2(N_CH);
    localparam int TW = $clog2(PERIOD_CYC);
    localparam int AW = $clog2(CORE_ABORT_CYC + 1);

    sched_state_t    state;
    sched_state_t    next_state;
    logic [TW-1:0]   timer;
    logic [AW-1:0]   abort_cnt;
    logic [CW-1:0]   last_ch;
    logic [CW-1:0]   pick_ch;
    logic            pick_any;
    logic            res_hit;
    logic            res_timeout;

    hcsr04_rr_pick #(
        .N_CH (N_CH)
    ) u_pick (
        .mask      (ch_mask),
        .last_ch   (last_ch),
        .next_ch   (pick_ch),
        .any_valid (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        res_hit     = 1'b0;
        res_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && pick_any) begin
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                next_state = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                // A result arriving on the timeout cycle still counts as success.
                if (core_val) begin
                    res_hit    = 1'b1;
                    next_state = ST_HOLDOFF;
                end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
                    res_timeout = 1'b1;
                    next_state  = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (abort_cnt == AW'(CORE_ABORT_CYC - 1)) begin
                    next_state = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (timer == TW'(PERIOD_CYC - 1)) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Timer is zero in ISSUE and runs uninterrupted to the end of the slot,
    // so slot length does not depend on how the measurement ended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer      <= '0;
            abort_cnt  <= '0;
            last_ch    <= CW'(N_CH - 1);
            sel        <= '0;
            res_dist   <= '0;
            res_new    <= '0;
            res_err    <= '0;
            core_start <= 1'b0;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
        end else begin
            timer     <= (state == ST_IDLE) ? '0 : timer + 1'b1;
            abort_cnt <= (state == ST_ABORT) ? abort_cnt + 1'b1 : '0;

            if ((state == ST_IDLE) && (next_state == ST_ISSUE)) begin
                sel     <= pick_ch;
                last_ch <= pick_ch;
            end

            res_new <= '0;
            for (int k = 0; k < N_CH; k++) begin
                if (sel == CW'(k)) begin
                    if (res_hit) begin
                        res_dist[k*DIST_W +: DIST_W] <= core_dist;
                        res_new[k]                   <= 1'b1;
                        res_err[k]                   <= 1'b0;
                    end else if (res_timeout) begin
                        res_err[k] <= 1'b1;
                    end
                end
            end

            core_start <= (next_state == ST_ISSUE);
            core_rst_n <= (next_state != ST_ABORT);
            busy       <= (next_state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_hcsr04_scheduler.sv
// Bench for hcsr04_scheduler: slot-age reference model checked every cycle plus directed scenarios.
// Small slot parameters keep every scenario to a few hundred cycles.
module tb_hcsr04_scheduler;
    localparam int N   = 4;
    localparam int PER = 200;
    localparam int TO  = 100;
    localparam int DW  = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N-1:0]    ch_mask;
    logic            core_start;
    logic            core_val;
    logic [DW-1:0]   core_dist;
    logic            core_rst_n;
    logic [1:0]      sel;
    logic [N*DW-1:0] res_dist;
    logic [N-1:0]    res_new;
    logic [N-1:0]    res_err;
    logic            busy;

    hcsr04_scheduler #(.N_CH(N), .PERIOD_CYC(PER), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask),
        .core_start(core_start), .core_val(core_val), .core_dist(core_dist),
        .core_rst_n(core_rst_n), .sel(sel), .res_dist(res_dist),
        .res_new(res_new), .res_err(res_err), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int start_q[$];
    int sel_q[$];
    int new_cnt [N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural core: answers dly[ch] cycles after start (negative = never answers).
    int          dly  [N];
    logic [DW-1:0] dval [N];
    bit          stray_req;
    int          cnt = -1;
    logic [DW-1:0] cur;

    initial begin
        core_val  = 1'b0;
        core_dist = '0;
        forever begin
            @(posedge clk);
            #1;
            core_val = 1'b0;
            if (rst) begin
                cnt = -1;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        core_val  = 1'b1;
                        core_dist = cur;
                        cnt       = -1;
                    end
                end
                if (core_start && dly[sel] > 0) begin
                    cnt = dly[sel];
                    cur = dval[sel];
                end
                if (stray_req) begin
                    core_val  = 1'b1;
                    core_dist = 12'd999;
                    stray_req = 1'b0;
                end
            end
        end
    end

    // Reference model: a slot is described only by its age since the start pulse.
    int          age = -1;
    int          m_last = N - 1;
    int          m_sel = 0;
    bit          m_done, m_to;
    logic [DW-1:0] m_dist [N];
    logic [N-1:0]  m_new, m_err;

    always @(negedge clk) begin : cmp
        logic [N*DW-1:0] e_dist;
        int              c;
        bit              found;
        cyc++;
        if (rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_start", core_start, 0);
            chk("rst_core_rst_n", core_rst_n, 0);
            chk("rst_sel", sel, 0);
            chk("rst_res", {res_dist, res_new, res_err}, 0);
            age = -1; m_last = N - 1; m_sel = 0; m_new = '0; m_err = '0;
            for (int k = 0; k < N; k++) m_dist[k] = '0;
        end else begin
            for (int k = 0; k < N; k++) e_dist[k*DW +: DW] = m_dist[k];
            chk("busy", busy, age >= 0);
            chk("core_start", core_start, age == 0);
            chk("sel", sel, m_sel);
            chk("core_rst_n", core_rst_n, !(m_to && (age == TO || age == TO + 1)));
            chk("res_dist", res_dist, e_dist);
            chk("res_new", res_new, m_new);
            chk("res_err", res_err, m_err);
            if (core_start) begin
                start_q.push_back(cyc);
                sel_q.push_back(int'(sel));
            end
            for (int k = 0; k < N; k++) if (res_new[k]) new_cnt[k]++;
            m_new = '0;
            if (age < 0) begin
                if (en && ch_mask != 0) begin
                    found = 0;
                    for (int i = 1; i <= N; i++) begin
                        c = (m_last + i) % N;
                        if (!found && ((ch_mask >> c) & 1)) begin
                            found = 1; m_sel = c;
                        end
                    end
                    m_last = m_sel; age = 0; m_done = 0; m_to = 0;
                end
            end else begin
                if (!m_done && age >= 1 && age <= TO - 1 && core_val) begin
                    m_done = 1; m_dist[m_sel] = core_dist; m_new[m_sel] = 1'b1; m_err[m_sel] = 1'b0;
                end else if (!m_done && age == TO - 1) begin
                    m_done = 1; m_to = 1; m_err[m_sel] = 1'b1;
                end
                age++;
                if (age == PER) age = -1;
            end
        end
    end

    task automatic wait_starts(input int n, input int budget);
        int t = 0;
        while (start_q.size() < n && t < budget) begin
            @(negedge clk); #1; t++;
        end
        if (start_q.size() < n) chk("start_timeout", start_q.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (busy && t < budget) begin
            @(negedge clk); #1; t++;
        end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int b, s0, lows, ns;
    int exp_rr [5] = '{0, 1, 3, 0, 1};

    initial begin
        rst = 1'b1; en = 1'b0; ch_mask = '0; stray_req = 1'b0;
        for (int k = 0; k < N; k++) begin dly[k] = -1; dval[k] = '0; new_cnt[k] = 0; end
        repeat (3) @(negedge clk);
        chk("init_busy", busy, 0);
        chk("init_core_rst_n", core_rst_n, 0);
        chk("init_res_dist", res_dist, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("core_rst_n_release", core_rst_n, 1);

        // Round-robin over mask 1011
        @(posedge clk); #1;
        dly = '{30, 30, 30, 30}; dval[0] = 12'd100; dval[1] = 12'd200; dval[3] = 12'd300;
        ch_mask = 4'b1011; en = 1'b1;
        wait_starts(5, 1200);
        en = 1'b0;
        for (int i = 0; i < 5; i++) if (i < sel_q.size()) chk("rr_sel", sel_q[i], exp_rr[i]);
        wait_idle(300);
        chk("rr_dist_ch3", res_dist[3*DW +: DW], 300);

        // Single channel
        b = start_q.size(); ns = new_cnt[0];
        @(posedge clk); #1;
        dly[0] = 40; dval[0] = 12'd1234; ch_mask = 4'b0001; en = 1'b1;
        wait_starts(b + 2, 600);
        chk("single_gap", start_q[b+1] - start_q[b], 201);
        chk("single_new_once", new_cnt[0] - ns, 1);
        chk("single_dist", res_dist[DW-1:0], 1234);
        en = 1'b0;
        wait_idle(300);

        // Timeout on ch1, then recovery
        b = start_q.size();
        @(posedge clk); #1;
        dly[1] = -1; ch_mask = 4'b0010; en = 1'b1;
        wait_starts(b + 1, 300);
        repeat (100) @(negedge clk);
        chk("to_err_set", res_err[1], 1);
        chk("to_rst_n_a", core_rst_n, 0);
        @(negedge clk); chk("to_rst_n_b", core_rst_n, 0);
        @(negedge clk); chk("to_rst_n_end", core_rst_n, 1);
        dly[1] = 50; dval[1] = 12'd777;
        wait_starts(b + 2, 300);
        chk("to_gap", start_q[b+1] - start_q[b], 201);
        repeat (60) @(negedge clk);
        chk("to_err_clear", res_err[1], 0);
        chk("to_new_dist", res_dist[DW +: DW], 777);
        en = 1'b0;
        wait_idle(300);

        // Result on the timeout cycle, then a stray core_val in HOLDOFF
        b = start_q.size();
        @(posedge clk); #1;
        dly[2] = 99; dval[2] = 12'd555; ch_mask = 4'b0100; en = 1'b1;
        wait_starts(b + 1, 300);
        en = 1'b0;
        lows = 0;
        repeat (110) begin @(negedge clk); if (!core_rst_n) lows++; end
        chk("race_no_abort", lows, 0);
        chk("race_err", res_err[2], 0);
        chk("race_dist", res_dist[2*DW +: DW], 555);
        @(posedge clk); #1 stray_req = 1'b1;
        repeat (5) @(negedge clk);
        chk("stray_ignored", res_dist[2*DW +: DW], 555);
        wait_idle(300);

        // Disable mid-slot, then empty mask
        b = start_q.size();
        @(posedge clk); #1;
        dly[0] = 20; dval[0] = 12'd4000; ch_mask = 4'b0001; en = 1'b1;
        wait_starts(b + 1, 300);
        s0 = (start_q.size() > b) ? start_q[b] : cyc;
        repeat (10) @(posedge clk);
        #1 en = 1'b0;
        while (cyc < s0 + 199) begin @(negedge clk); #1; end
        chk("dis_busy_199", busy, 1);
        @(negedge clk); #1;
        chk("dis_busy_200", busy, 0);
        chk("dis_dist", res_dist[DW-1:0], 4000);
        ns = start_q.size();
        repeat (300) @(negedge clk);
        chk("dis_no_start", start_q.size() - ns, 0);
        @(posedge clk); #1 ch_mask = 4'b0000; en = 1'b1;
        repeat (50) @(negedge clk);
        chk("mask0_no_start", start_q.size() - ns, 0);
        chk("mask0_busy", busy, 0);

        // Asynchronous reset in the middle of WAIT_RES
        b = start_q.size();
        @(posedge clk); #1;
        dly[0] = -1; ch_mask = 4'b0001;
        wait_starts(b + 1, 300);
        repeat (20) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1; en = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_core_rst_n", core_rst_n, 0);
        chk("arst_res_dist", res_dist, 0);
        chk("arst_res_err", res_err, 0);
        chk("arst_res_new", res_new, 0);
        @(negedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("arst_core_rst_n_rise", core_rst_n, 1);
        b = start_q.size();
        @(posedge clk); #1 ch_mask = 4'b1111; en = 1'b1;
        wait_starts(b + 1, 20);
        if (sel_q.size() > b) chk("first_pick_ch0", sel_q[b], 0);
        en = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
